dma_rx_que: RTL and testbench
=============================

Name: dma_rx_que

Overview:
- Receive-direction descriptor/completion queue for the LLDMA RX path.
- Write side is fire-and-forget. Host completions cannot be back-pressured, so there is no ready on the write side; a write into a full queue is dropped and recorded.
- Read side is a registered valid/ready handshake towards the RX DMA engine.
- Provides occupancy level, almost-full for upstream credit throttling, a sticky overflow flag and a saturating drop counter.

Parameters:
- Q_DT_WIDTH, 144, entry width in bits (128 data + 16 control).
- Q_DEPTH_LOG2, 2, log2 of total capacity; DEPTH = 2**Q_DEPTH_LOG2 entries.
- AFULL_TH, 3, afull asserts when level >= AFULL_TH; legal range 1..DEPTH.

Ports:
- user_clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush, highest priority
- we  in  1  write strobe, one entry per cycle
- wd  in  Q_DT_WIDTH  write data
- out_valid  out  1  head entry valid (registered)
- out_ready  in  1  consumer accepts head
- out_data  out  Q_DT_WIDTH  head entry (registered)
- level  out  Q_DEPTH_LOG2+1  entries held, registered
- afull  out  1  level >= AFULL_TH
- full  out  1  level == DEPTH
- ovfl  out  1  sticky: a write was dropped
- drop_cnt  out  16  saturating count of dropped writes

Behaviour:
- Reset (reset_n=0): out_valid=0, out_data=0, level=0, afull=0, full=0, ovfl=0, drop_cnt=0, all storage pointers 0.
- Storage:
  - Circular array plus output register; total capacity exactly DEPTH entries, counting the output register.
  - Pointers carry one extra wrap bit and wrap modulo DEPTH.
- Ordering: strict FIFO.
- Push: accepted when we=1, clr=0, full=0.
- Pop: happens when out_valid=1 && out_ready=1.
- level: next = level + push - pop; simultaneous push and pop leaves level unchanged.
- full and afull:
  - Decoded combinationally from the level register only; no combinational path from we or out_ready.
- Latency:
  - A write into an empty queue at edge N gives out_valid=1 and out_data=wd after edge N+1.
  - Back-to-back entries present one per cycle while out_ready=1.
- Hold rule:
  - While out_valid=1 && out_ready=0, out_data and out_valid stay stable.
  - When out_valid=0, out_data holds its last value.
- Drop:
  - Condition: we=1 && full=1 && clr=0.
  - The entry is discarded and ovfl is set to 1.
  - drop_cnt increments and saturates at 16'hFFFF.
  - A pop in the same cycle does NOT rescue the write: the drop decision uses the registered full.
- out_ready with out_valid=0: ignored, no state change, no error.
- clr:
  - Next cycle: out_valid=0, level=0, full=0, afull=0, ovfl=0, drop_cnt=0, pointers 0.
  - A we in the same cycle is discarded and not counted.
  - A pending head is discarded.
  - out_data is left unchanged.
- Wrap-around: after any number of fill/drain cycles, ordering and level remain exact; pointer wrap bit distinguishes full from empty.

Optional Feature:
- Macro: DMA_RX_QUE_PARITY_EN.
- Enabled:
  - Each entry stores an even-parity bit over wd, computed at push.
  - Extra input par_inj (1 bit): when 1 at push, the stored parity bit is inverted.
  - Extra output perr (1 bit, reset 0):
    - Set one cycle after a pop whose stored parity mismatches out_data.
    - Sticky; cleared only by reset or clr.
  - Data path and timing are otherwise identical.
- Disabled: no parity storage, no par_inj/perr ports.

Test Plan:
- Reset:
  - Stimulus: hold reset_n=0 for 3 cycles, release, drive we=0.
  - Required: out_valid=0, level=0, full=0, afull=0, ovfl=0, drop_cnt=0 for 5 cycles.
- Single write:
  - Stimulus: we=1 with wd=144'h...00A5 at edge N, out_ready=0.
  - Required: out_valid=1, out_data=...00A5, level=1 after N+1, stable for 4 cycles.
  - Then: out_ready=1 for 1 cycle gives out_valid=0, level=0.
- Fill and overflow:
  - Stimulus: write 1,2,3,4 back-to-back with out_ready=0.
  - Required: afull=1 at level=3; full=1 at level=4.
  - Then: write 5 gives ovfl=1, drop_cnt=1, level=4.
  - Then: drain with out_ready=1 yields 1,2,3,4 on consecutive cycles; 5 never appears.
- Simultaneous push/pop and wrap:
  - Stimulus: at level=2, push and pop together for 10 cycles.
  - Required: level stays 2, outputs in exact write order across pointer wrap.
  - Then: with full=1, push+pop in the same cycle drops the write (drop_cnt+1) and level becomes 3.
- clr mid-operation:
  - Stimulus: at level=3 with ovfl=1, assert clr together with we.
  - Required: next cycle out_valid=0, level=0, ovfl=0, drop_cnt=0.
  - Then: a subsequent write appears after 1 cycle.
- Parity (DMA_RX_QUE_PARITY_EN defined):
  - Stimulus: write A with par_inj=1, then B with par_inj=0; pop both.
  - Required: perr=1 one cycle after A's pop, stays 1 through B's pop; clr returns perr=0.

Source files
------------

// File: rtl/dma_rx_que.sv
// dma_rx_que: RX descriptor/completion queue, drop-on-full write side, registered valid/ready read side.
// Optional DMA_RX_QUE_PARITY_EN adds per-entry even parity with par_inj/perr.
module dma_rx_que #(
  parameter int Q_DT_WIDTH   = 144,
  parameter int Q_DEPTH_LOG2 = 2,
  parameter int AFULL_TH     = 3
) (
  input  logic                  user_clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [Q_DT_WIDTH-1:0] wd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q_DT_WIDTH-1:0] out_data,
  output logic [Q_DEPTH_LOG2:0] level,
  output logic                  afull,
  output logic                  full,
  output logic                  ovfl,
  output logic [15:0]           drop_cnt
`ifdef DMA_RX_QUE_PARITY_EN
  ,
  input  logic                  par_inj,
  output logic                  perr
`endif
);
  localparam int AW = Q_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_TH);
`ifdef DMA_RX_QUE_PARITY_EN
  localparam int EW = Q_DT_WIDTH + 1;
`else
  localparam int EW = Q_DT_WIDTH;
`endif
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] ent_q, ent_d, wr_ent;
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d, lvl_q, lvl_d;
  logic          vld_q, vld_d, ov_q, ov_d, perr_q, perr_d;
  logic [15:0]   dc_q, dc_d;
  logic          push, drop, pop, load;
  assign full      = lvl_q == DEPTH_L;
  assign afull     = lvl_q >= AFULL_L;
  assign level     = lvl_q;
  assign out_valid = vld_q;
  assign out_data  = ent_q[Q_DT_WIDTH-1:0];
  assign ovfl      = ov_q;
  assign drop_cnt  = dc_q;
`ifdef DMA_RX_QUE_PARITY_EN
  assign wr_ent = {^wd ^ par_inj, wd};
  assign perr   = perr_q;
`else
  assign wr_ent = wd;
`endif
  // Array count is level minus the output register, so the array alone never overruns.
  always_comb begin
    push   = we & ~clr & ~full;
    drop   = we & ~clr & full;
    pop    = vld_q & out_ready;
    load   = (wp_q != rp_q) & (~vld_q | pop);
    wp_d   = clr ? '0 : wp_q + (AW+1)'(push);
    rp_d   = clr ? '0 : rp_q + (AW+1)'(load);
    lvl_d  = clr ? '0 : lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    vld_d  = ~clr & (load | (vld_q & ~pop));
    ent_d  = (load & ~clr) ? mem_q[rp_q[AW-1:0]] : ent_q;
    ov_d   = ~clr & (ov_q | drop);
    dc_d   = clr ? '0 : dc_q + 16'(drop && dc_q != 16'hFFFF);
`ifdef DMA_RX_QUE_PARITY_EN
    perr_d = ~clr & (perr_q | (pop & (ent_q[EW-1] != ^ent_q[Q_DT_WIDTH-1:0])));
`else
    perr_d = 1'b0;
`endif
  end
  always_ff @(posedge user_clk)
    if (push) mem_q[wp_q[AW-1:0]] <= wr_ent;
  always_ff @(posedge user_clk or negedge reset_n)
    if (!reset_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      vld_q  <= 1'b0;
      ent_q  <= '0;
      ov_q   <= 1'b0;
      dc_q   <= '0;
      perr_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      vld_q  <= vld_d;
      ent_q  <= ent_d;
      ov_q   <= ov_d;
      dc_q   <= dc_d;
      perr_q <= perr_d;
    end
endmodule

// File: tb/tb_dma_rx_que.sv
// tb_dma_rx_que: scoreboard bench for dma_rx_que (default parameters).
module tb_dma_rx_que;
  logic         user_clk = 0, reset_n = 0, clr = 0, we = 0, out_ready = 0, par_inj = 0;
  logic [143:0] wd = '0;
  logic         out_valid, afull, full, ovfl, perr;
  logic [143:0] out_data;
  logic [2:0]   level;
  logic [15:0]  drop_cnt;
  logic [143:0] sb[$];
  logic [143:0] exp_d;
  int n_chk = 0, n_fail = 0, mlvl = 0, mdrop = 0;
  logic movf = 0;

  dma_rx_que dut (
    .user_clk(user_clk), .reset_n(reset_n), .clr(clr), .we(we), .wd(wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .afull(afull), .full(full), .ovfl(ovfl), .drop_cnt(drop_cnt)
`ifdef DMA_RX_QUE_PARITY_EN
    , .par_inj(par_inj), .perr(perr)
`endif
  );
`ifndef DMA_RX_QUE_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 user_clk = ~user_clk;

  // One clock: drive inputs, update the scoreboard/model, then check after the edge.
  task automatic cyc(input logic w, input logic [143:0] d, input logic r,
                     input logic c = 0, input logic pi = 0);
    logic do_pop;
    we = w; wd = d; out_ready = r; clr = c; par_inj = pi;
    do_pop = out_valid && r;
    if (c) begin
      sb.delete(); mlvl = 0; mdrop = 0; movf = 0;
    end else begin
      if (do_pop) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL pop_unexpected: out_data=%h with empty scoreboard", out_data);
        end else begin
          exp_d = sb.pop_front();
          if (out_data !== exp_d) begin
            n_fail++; $display("FAIL pop_data: got %h expected %h", out_data, exp_d);
          end
        end
      end
      if (w && mlvl < 4) sb.push_back(d);
      if (w && mlvl == 4) begin
        movf = 1; if (mdrop < 65535) mdrop++;
      end
      mlvl = mlvl + ((w && mlvl < 4) ? 1 : 0) - (do_pop ? 1 : 0);
    end
    @(posedge user_clk); #1;
    we = 0; clr = 0; out_ready = 0; par_inj = 0;
    n_chk++;
    if (level !== 3'(mlvl) || full !== (mlvl == 4) || afull !== (mlvl >= 3) ||
        ovfl !== movf || drop_cnt !== 16'(mdrop)) begin
      n_fail++;
      $display("FAIL status: level=%0d full=%b afull=%b ovfl=%b drop=%0d expected %0d %b %b %b %0d",
               level, full, afull, ovfl, drop_cnt, mlvl, mlvl == 4, mlvl >= 3, movf, mdrop);
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(posedge user_clk);
    #1 reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 0);
      n_chk++;
      if (out_valid !== 0 || out_data !== '0) begin
        n_fail++; $display("FAIL reset_out: valid=%b data=%h expected 0 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_single;
    cyc(1, 144'hA5, 0);
    n_chk++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL single_latency: valid=%b expected 0 one edge after write", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0);
      n_chk++;
      if (out_valid !== 1 || out_data !== 144'hA5) begin
        n_fail++; $display("FAIL single_hold: valid=%b data=%h expected 1 a5", out_valid, out_data);
      end
    end
    cyc(0, '0, 1);
    n_chk++;
    if (out_valid !== 0 || out_data !== 144'hA5) begin
      n_fail++; $display("FAIL single_pop: valid=%b data=%h expected 0 a5 (held)", out_valid, out_data);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 4; i++) cyc(1, 144'(i), 0);
    cyc(1, 144'd5, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_valid !== 1) begin
        n_fail++; $display("FAIL drain_valid: cycle %0d valid=%b expected 1", i, out_valid);
      end
      cyc(0, '0, 1);
    end
    n_chk++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL drain_empty: valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_push_pop_wrap;
    cyc(1, 144'h100, 0);
    cyc(1, 144'h101, 0);
    cyc(0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (out_valid !== 1) begin
        n_fail++; $display("FAIL wrap_valid: cycle %0d valid=%b expected 1", i, out_valid);
      end
      cyc(1, 144'h200 + 144'(i), 1);
    end
    cyc(1, 144'h300, 0);
    cyc(1, 144'h301, 0);
    cyc(1, 144'h3FF, 1);
  endtask

  task automatic test_clr;
    n_chk++;
    if (level !== 3 || ovfl !== 1) begin
      n_fail++; $display("FAIL clr_pre: level=%0d ovfl=%b expected 3 1", level, ovfl);
    end
    cyc(1, 144'hBAD, 0, 1);
    n_chk++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL clr_valid: valid=%b expected 0", out_valid);
    end
    cyc(1, 144'hC0DE, 0);
    cyc(0, '0, 0);
    n_chk++;
    if (out_valid !== 1 || out_data !== 144'hC0DE) begin
      n_fail++; $display("FAIL clr_after_write: valid=%b data=%h expected 1 c0de", out_valid, out_data);
    end
    cyc(0, '0, 1);
  endtask

  task automatic test_parity;
    cyc(1, 144'h7, 0, 0, 1);
    cyc(1, 144'h3, 0, 0, 0);
    cyc(0, '0, 0);
    n_chk++;
    if (perr !== 0) begin
      n_fail++; $display("FAIL perr_pre: perr=%b expected 0", perr);
    end
    cyc(0, '0, 1);
    n_chk++;
    if (perr !== 1) begin
      n_fail++; $display("FAIL perr_set: perr=%b expected 1", perr);
    end
    cyc(0, '0, 1);
    n_chk++;
    if (perr !== 1) begin
      n_fail++; $display("FAIL perr_sticky: perr=%b expected 1", perr);
    end
    cyc(0, '0, 0, 1);
    n_chk++;
    if (perr !== 0) begin
      n_fail++; $display("FAIL perr_clr: perr=%b expected 0", perr);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_overflow;
    test_push_pop_wrap;
    test_clr;
`ifdef DMA_RX_QUE_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
